// File: rtl/egr_tcu_pop_arb.sv
`default_nettype none
// ============================================================================
// Module   : egr_tcu_pop_arb
// Purpose  : TCU-side pop scheduler on the TQU->TCU boundary. Picks one ready
//            queue per cycle round-robin and issues a registered one-hot pop
//            to the TQU. Each pop is gated by a per-queue downstream credit
//            and by an in-flight limit. Issued queue IDs are kept in a FIFO
//            so returning TQU data can be checked for order and forwarded
//            downstream.
// Ports    : cclk, rst_n        - clock, synchronous active-low reset
//            tqu_data_ready     - per-queue "TQU holds a word"
//            q_enable           - per-queue software enable
//            tcu_pop            - one-hot pop to the TQU (registered)
//            tqu_data_valid/tqu_data/tqu_data_qid - returned TQU word
//            out_valid/out_data/out_qid           - forwarded word
//            credit_ret_valid/credit_ret_qid      - downstream credit return
//            outstanding        - pops issued whose data has not returned
//            err_unexp/err_order/err_credit/err_timeout - sticky errors
// Options  : define EGR_TCU_POP_TIMEOUT_EN to build the in-flight watchdog
//            (TIMEOUT_CYC cycles); otherwise err_timeout is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module egr_tcu_pop_arb #(
  parameter int NUM_Q       = 36,
  parameter int QW          = 6,
  parameter int DATA_W      = 128,
  parameter int CREDITS     = 4,
  parameter int MAX_OUT     = 8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                     cclk,
  input  logic                     rst_n,
  input  logic [NUM_Q-1:0]         tqu_data_ready,
  output logic [NUM_Q-1:0]         tcu_pop,
  input  logic [NUM_Q-1:0]         q_enable,
  input  logic                     tqu_data_valid,
  input  logic [DATA_W-1:0]        tqu_data,
  input  logic [QW-1:0]            tqu_data_qid,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [QW-1:0]            out_qid,
  input  logic                     credit_ret_valid,
  input  logic [QW-1:0]            credit_ret_qid,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     err_unexp,
  output logic                     err_order,
  output logic                     err_credit,
  output logic                     err_timeout
);

  localparam int c_PW = $clog2(MAX_OUT);
  localparam int c_CW = $clog2(CREDITS + 1);

  localparam logic [c_PW:0]   c_CNT_ONE = (c_PW + 1)'(1);
  localparam logic [c_PW:0]   c_CNT_MAX = (c_PW + 1)'(MAX_OUT);
  localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
  localparam logic [c_CW-1:0] c_CRD_ONE = c_CW'(1);
  localparam logic [c_CW-1:0] c_CRD_MAX = c_CW'(CREDITS);
  localparam logic [QW-1:0]   c_QID_ONE = QW'(1);
  localparam logic [QW-1:0]   c_LAST_Q  = QW'(NUM_Q - 1);
  localparam logic [QW:0]     c_NUM_Q_X = (QW + 1)'(NUM_Q);

  // Elaboration-time guard against illegal parameter sets.
  if (((2 ** QW) < NUM_Q) || (MAX_OUT < 2) || ((MAX_OUT & (MAX_OUT - 1)) != 0) ||
      (CREDITS < 1) || (TIMEOUT_CYC < 1)) begin : g_param_chk
    $error("egr_tcu_pop_arb: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NUM_Q-1:0]  pop_q, pop_d;
  logic [QW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [QW-1:0]     fifo_mem_q [MAX_OUT];
  logic [c_PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_PW:0]     count_q, count_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [QW-1:0]     out_qid_q;
  logic              err_unexp_q, err_order_q, err_credit_q;

  logic [NUM_Q-1:0]  crd_avail;
  logic [NUM_Q-1:0]  crd_ovf;
  logic [NUM_Q-1:0]  elig;
  logic              gnt_vld;
  logic [QW-1:0]     gnt_idx;
  logic [QW:0]       rr_sum;
  logic [QW-1:0]     rr_idx;
  logic              fifo_push, fifo_pop, fifo_empty, not_full;
  logic [QW-1:0]     fifo_head;
  logic              credit_bad_qid;

  // --------------------------------------------------------------------------
  // Eligibility and round-robin arbitration
  // --------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  // A same-cycle data return does not free a slot for this cycle's grant.
  assign not_full   = (count_q != c_CNT_MAX);

  // The queue popped last cycle is excluded: its ready bit is still stale
  // because the TQU updates ready one cycle after a pop.
  assign elig = tqu_data_ready & q_enable & crd_avail & ~pop_q & {NUM_Q{not_full}};

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    rr_idx  = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      rr_sum = {1'b0, rr_ptr_q} + (QW + 1)'(i);
      if (rr_sum >= c_NUM_Q_X) begin
        rr_sum = rr_sum - c_NUM_Q_X;
      end
      rr_idx = rr_sum[QW-1:0];
      if (!gnt_vld && elig[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  always_comb begin
    pop_d    = '0;
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      pop_d[gnt_idx] = 1'b1;
      rr_ptr_d       = (gnt_idx == c_LAST_Q) ? '0 : (gnt_idx + c_QID_ONE);
    end
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      pop_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      pop_q    <= pop_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // In-flight queue-ID FIFO
  // --------------------------------------------------------------------------
  assign fifo_push = gnt_vld;
  assign fifo_pop  = tqu_data_valid && !fifo_empty;
  assign fifo_head = fifo_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (fifo_push && !fifo_pop) begin
      count_d = count_q + c_CNT_ONE;
    end else if (fifo_pop && !fifo_push) begin
      count_d = count_q - c_CNT_ONE;
    end
  end

  // Storage is not reset; clearing the pointers discards its contents.
  always_ff @(posedge cclk) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-queue credit counters
  // --------------------------------------------------------------------------
  for (genvar q = 0; q < NUM_Q; q++) begin : g_credit
    logic [c_CW-1:0] cnt_q;
    logic            take, give, at_max;

    assign take         = gnt_vld && (gnt_idx == QW'(q));
    assign give         = credit_ret_valid && (credit_ret_qid == QW'(q));
    assign at_max       = (cnt_q == c_CRD_MAX);
    assign crd_avail[q] = (cnt_q != '0);
    // A return to a full counter is an error even when a pop consumes a
    // credit in the same cycle; the counter is simply left unchanged then.
    assign crd_ovf[q]   = give && at_max;

    always_ff @(posedge cclk) begin
      if (!rst_n) begin
        cnt_q <= c_CRD_MAX;
      end else if (take && !give) begin
        cnt_q <= cnt_q - c_CRD_ONE;
      end else if (give && !take && !at_max) begin
        cnt_q <= cnt_q + c_CRD_ONE;
      end
    end
  end

  assign credit_bad_qid = credit_ret_valid && ({1'b0, credit_ret_qid} >= c_NUM_Q_X);

  // --------------------------------------------------------------------------
  // Data forwarding and sticky errors
  // --------------------------------------------------------------------------
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_qid_q    <= '0;
      err_unexp_q  <= 1'b0;
      err_order_q  <= 1'b0;
      err_credit_q <= 1'b0;
    end else begin
      out_valid_q <= fifo_pop;
      if (fifo_pop) begin
        out_data_q <= tqu_data;
        out_qid_q  <= fifo_head;
      end
      err_unexp_q  <= err_unexp_q  | (tqu_data_valid && fifo_empty);
      err_order_q  <= err_order_q  | (fifo_pop && (tqu_data_qid != fifo_head));
      err_credit_q <= err_credit_q | (|crd_ovf) | credit_bad_qid;
    end
  end

  // --------------------------------------------------------------------------
  // Optional in-flight watchdog
  // --------------------------------------------------------------------------
`ifdef EGR_TCU_POP_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TW-1:0] c_TO_ONE = c_TW'(1);
  localparam logic [c_TW-1:0] c_TO_MAX = c_TW'(TIMEOUT_CYC);

  logic [c_TW-1:0] to_cnt_q, to_cnt_d;
  logic            err_timeout_q;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (tqu_data_valid || fifo_empty) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != c_TO_MAX) begin
      to_cnt_d = to_cnt_q + c_TO_ONE;
    end
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_q | (to_cnt_d == c_TO_MAX);
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign tcu_pop     = pop_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_qid     = out_qid_q;
  assign outstanding = count_q;
  assign err_unexp   = err_unexp_q;
  assign err_order   = err_order_q;
  assign err_credit  = err_credit_q;

endmodule
`default_nettype wire

// File: tb/tb_egr_tcu_pop_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_egr_tcu_pop_arb
// Purpose  : Directed self-checking bench for egr_tcu_pop_arb. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_egr_tcu_pop_arb;

  localparam int NUM_Q  = 36;
  localparam int QW     = 6;
  localparam int DATA_W = 128;

  logic              cclk = 1'b0;
  logic              rst_n;
  logic [NUM_Q-1:0]  tqu_data_ready;
  logic [NUM_Q-1:0]  tcu_pop;
  logic [NUM_Q-1:0]  q_enable;
  logic              tqu_data_valid;
  logic [DATA_W-1:0] tqu_data;
  logic [QW-1:0]     tqu_data_qid;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [QW-1:0]     out_qid;
  logic              credit_ret_valid;
  logic [QW-1:0]     credit_ret_qid;
  logic [3:0]        outstanding;
  logic              err_unexp, err_order, err_credit, err_timeout;

  egr_tcu_pop_arb u_dut (
    .cclk             (cclk),
    .rst_n            (rst_n),
    .tqu_data_ready   (tqu_data_ready),
    .tcu_pop          (tcu_pop),
    .q_enable         (q_enable),
    .tqu_data_valid   (tqu_data_valid),
    .tqu_data         (tqu_data),
    .tqu_data_qid     (tqu_data_qid),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_qid          (out_qid),
    .credit_ret_valid (credit_ret_valid),
    .credit_ret_qid   (credit_ret_qid),
    .outstanding      (outstanding),
    .err_unexp        (err_unexp),
    .err_order        (err_order),
    .err_credit       (err_credit),
    .err_timeout      (err_timeout)
  );

  always #5 cclk = ~cclk;

  int n_chk  = 0;
  int n_fail = 0;

  int exp_pop [6] = '{3, 7, 35, 3, 7, 35};
  int exp_out [9] = '{1, 2, 3, 3, 3, 3, 2, 1, 0};

  int           n_pops;
  int           n_other;
  logic [35:0]  first_pop;
  logic [35:0]  mask20;
  logic         exp_to;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge cclk);
  endtask

  function automatic logic [35:0] qbit(input int k);
    qbit = 36'd1 << k;
  endfunction

  function automatic logic [127:0] pat(input int k);
    pat = {4{32'hA5A5_0000 + 32'(k)}};
  endfunction

  initial begin
    rst_n            = 1'b0;
    tqu_data_ready   = '0;
    q_enable         = '1;
    tqu_data_valid   = 1'b0;
    tqu_data         = '0;
    tqu_data_qid     = '0;
    credit_ret_valid = 1'b0;
    credit_ret_qid   = '0;
`ifdef EGR_TCU_POP_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_tcu_pop",     tcu_pop,     0);
    chk("rst_out_valid",   out_valid,   0);
    chk("rst_out_data",    out_data,    0);
    chk("rst_out_qid",     out_qid,     0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_errs", {err_unexp, err_order, err_credit, err_timeout}, 0);

    // ---------------- first pop one cycle after reset ----------------
    rst_n          = 1'b1;
    tqu_data_ready = qbit(0);
    tick();
    chk("t1_pop_q0", tcu_pop, qbit(0));
    tqu_data_ready = '0;
    tick();
    chk("t1_pop_clear", tcu_pop, 0);
    chk("t1_outstanding", outstanding, 1);
    tqu_data_valid   = 1'b1;
    tqu_data_qid     = 6'd0;
    tqu_data         = pat(100);
    credit_ret_valid = 1'b1;
    credit_ret_qid   = 6'd0;
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, pat(100));
    chk("t1_out_qid", out_qid, 0);
    chk("t1_outstanding_0", outstanding, 0);
    tqu_data_valid   = 1'b0;
    credit_ret_valid = 1'b0;

    // ---------------- round robin over 3, 7, 35 ----------------
    tqu_data_ready = qbit(3) | qbit(7) | qbit(35);
    for (int s = 0; s < 9; s++) begin
      tick();
      chk("t2_pop", tcu_pop, (s < 6) ? qbit(exp_pop[s]) : 36'd0);
      chk("t2_outstanding", outstanding, exp_out[s]);
      if (s >= 3) begin
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_qid", out_qid, exp_pop[s-3]);
        chk("t2_out_data", out_data, pat(s - 3));
      end else begin
        chk("t2_out_idle", out_valid, 0);
      end
      if (s == 5) tqu_data_ready = '0;
      if (s >= 2 && s <= 7) begin
        tqu_data_valid = 1'b1;
        tqu_data_qid   = QW'(exp_pop[s-2]);
        tqu_data       = pat(s - 2);
      end else begin
        tqu_data_valid = 1'b0;
      end
    end

    // ---------------- credit exhaustion on queue 5 ----------------
    tqu_data_ready = qbit(5);
    n_pops  = 0;
    n_other = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tcu_pop == qbit(5)) n_pops++;
      else if (tcu_pop != '0) n_other++;
    end
    chk("t3_pops_4", n_pops, 4);
    chk("t3_other", n_other, 0);
    chk("t3_outstanding", outstanding, 4);
    credit_ret_valid = 1'b1;
    credit_ret_qid   = 6'd5;
    tick();
    credit_ret_valid = 1'b0;
    n_pops = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tcu_pop == qbit(5)) n_pops++;
    end
    chk("t3_pops_after_ret", n_pops, 1);
    chk("t3_err_credit", err_credit, 0);
    chk("t3_outstanding_5", outstanding, 5);
    tqu_data_ready = '0;
    for (int i = 0; i < 5; i++) begin
      tqu_data_valid = 1'b1;
      tqu_data_qid   = 6'd5;
      tqu_data       = pat(50 + i);
      tick();
      chk("t3_drain_qid", out_qid, 5);
      chk("t3_drain_data", out_data, pat(50 + i));
    end
    tqu_data_valid = 1'b0;
    tick();
    chk("t3_drained", outstanding, 0);
    chk("t3_out_idle", out_valid, 0);

    // ---------------- in-flight limit ----------------
    mask20         = 36'hF_FFFF << 10;
    tqu_data_ready = mask20;
    n_pops    = 0;
    first_pop = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tcu_pop != '0) begin
        if (n_pops == 0) first_pop = tcu_pop;
        n_pops++;
      end
    end
    chk("t4_pops_8", n_pops, 8);
    chk("t4_first_q10", first_pop, qbit(10));
    chk("t4_outstanding_8", outstanding, 8);
    chk("t4_no_pop_full", tcu_pop, 0);
    tqu_data_valid = 1'b1;
    tqu_data_qid   = 6'd10;
    tqu_data       = pat(200);
    tick();
    chk("t4_same_cycle_no_grant", tcu_pop, 0);
    chk("t4_outstanding_7", outstanding, 7);
    chk("t4_out_qid_10", out_qid, 10);
    tqu_data_valid = 1'b0;
    tick();
    chk("t4_next_grant_q18", tcu_pop, qbit(18));
    chk("t4_outstanding_refill", outstanding, 8);
    tqu_data_ready = '0;
    for (int i = 0; i < 8; i++) begin
      tqu_data_valid = 1'b1;
      tqu_data_qid   = QW'(11 + i);
      tqu_data       = pat(300 + i);
      tick();
      chk("t4_drain_qid", out_qid, 11 + i);
    end
    tqu_data_valid = 1'b0;
    tick();
    chk("t4_drained", outstanding, 0);
    chk("t4_err_order", err_order, 0);

    // ---------------- unexpected data, order error ----------------
    chk("t5_unexp_pre", err_unexp, 0);
    tqu_data_valid = 1'b1;
    tqu_data_qid   = 6'd2;
    tqu_data       = pat(400);
    tick();
    chk("t5_err_unexp", err_unexp, 1);
    chk("t5_unexp_no_out", out_valid, 0);
    chk("t5_unexp_outstanding", outstanding, 0);
    tqu_data_valid = 1'b0;
    tqu_data_ready = qbit(4);
    tick();
    chk("t5_pop_q4", tcu_pop, qbit(4));
    chk("t5_order_pre", err_order, 0);
    tqu_data_ready = '0;
    tqu_data_valid = 1'b1;
    tqu_data_qid   = 6'd9;
    tqu_data       = pat(401);
    tick();
    chk("t5_err_order", err_order, 1);
    chk("t5_order_out_valid", out_valid, 1);
    chk("t5_order_out_qid", out_qid, 4);
    chk("t5_order_out_data", out_data, pat(401));
    tqu_data_valid = 1'b0;

    // ---------------- credit overflow ----------------
    chk("t6_credit_pre", err_credit, 0);
    credit_ret_valid = 1'b1;
    credit_ret_qid   = 6'd0;
    tick();
    credit_ret_valid = 1'b0;
    chk("t6_err_credit_full", err_credit, 1);

    // ---------------- reset mid-operation ----------------
    tqu_data_ready = qbit(4);
    tick();
    chk("t7_inflight", outstanding, 1);
    rst_n          = 1'b0;
    tqu_data_ready = '0;
    tick();
    tick();
    chk("t7_rst_outstanding", outstanding, 0);
    chk("t7_rst_errs", {err_unexp, err_order, err_credit}, 0);
    chk("t7_rst_pop", tcu_pop, 0);
    rst_n          = 1'b1;
    tqu_data_valid = 1'b1;
    tqu_data_qid   = 6'd4;
    tqu_data       = pat(500);
    tick();
    chk("t7_post_rst_unexp", err_unexp, 1);
    chk("t7_post_rst_no_out", out_valid, 0);
    tqu_data_valid   = 1'b0;
    credit_ret_valid = 1'b1;
    credit_ret_qid   = 6'd40;
    tick();
    credit_ret_valid = 1'b0;
    chk("t7_err_credit_badqid", err_credit, 1);

    // ---------------- watchdog ----------------
    rst_n = 1'b0;
    tick();
    rst_n          = 1'b1;
    tqu_data_ready = qbit(1);
    tick();
    chk("t8_pop_q1", tcu_pop, qbit(1));
    tqu_data_ready = '0;
    repeat (255) tick();
    chk("t8_timeout_early", err_timeout, 0);
    tick();
    chk("t8_timeout_256", err_timeout, exp_to);
    chk("t8_outstanding", outstanding, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/egr_tcu_pop_arb.md
Name: egr_tcu_pop_arb

Overview:
- TCU-side pop scheduler sitting directly downstream of the TQU on the TQU->TCU boundary.
- Chooses one ready queue per cycle, round-robin, and drives a one-hot per-queue pop to the TQU.
- Gates each pop on per-queue downstream credits and on an in-flight limit, matches returning TQU data against a FIFO of issued queue IDs, and forwards that data downstream.

Parameters:
- NUM_Q, 36, number of queues; width of the pop and ready vectors.
- QW, 6, queue-ID width; must satisfy 2^QW >= NUM_Q.
- DATA_W, 128, width of a TQU data word.
- CREDITS, 4, per-queue downstream credit count loaded at reset.
- MAX_OUT, 8, maximum pops in flight (issued, data not yet returned); power of 2.
- TIMEOUT_CYC, 256, watchdog limit in cycles; used only with the optional feature.

Ports:
- cclk, in, 1, the block's single clock.
- rst_n, in, 1, reset; synchronous, active-low.
- tqu_data_ready, in, NUM_Q, per queue: TQU holds at least one word.
- tcu_pop, out, NUM_Q, one-hot pop request to the TQU; one cycle per word.
- q_enable, in, NUM_Q, software per-queue enable.
- tqu_data_valid, in, 1, returned data word is valid.
- tqu_data, in, DATA_W, returned data word.
- tqu_data_qid, in, QW, queue the returned word belongs to.
- out_valid, out, 1, forwarded data valid.
- out_data, out, DATA_W, forwarded data word.
- out_qid, out, QW, queue ID from the FIFO head.
- credit_ret_valid, in, 1, downstream returns one credit.
- credit_ret_qid, in, QW, queue receiving the returned credit.
- outstanding, out, $clog2(MAX_OUT)+1, current in-flight count.
- err_unexp, out, 1, sticky: data arrived with the FIFO empty.
- err_order, out, 1, sticky: tqu_data_qid did not match the FIFO head.
- err_credit, out, 1, sticky: credit returned to a queue already at CREDITS.
- err_timeout, out, 1, sticky: watchdog expired.

Behaviour:
- Reset (rst_n=0 at a cclk edge):
  - tcu_pop=0, out_valid=0, out_data=0, out_qid=0, outstanding=0, all err_*=0.
  - Every credit counter loads CREDITS; RR pointer=0; FIFO empty; lockout cleared.
  - Reset asserted mid-operation discards in-flight state. Data returning after reset is treated as unexpected and raises err_unexp.
- Eligibility of queue q in cycle N: tqu_data_ready[q] & q_enable[q] & credit[q]>0 & q!=lockout_q & outstanding<MAX_OUT.
- Arbitration:
  - Round-robin, starting at RR pointer; the first eligible queue at or above the pointer (wrapping NUM_Q-1 -> 0) wins.
  - On a grant the pointer moves to winner+1, wrapping to 0 at NUM_Q. No grant leaves the pointer unchanged.
- Grant in cycle N causes:
  - tcu_pop[winner]=1 in cycle N+1 (registered output; one-hot or all-zero).
  - winner's QID pushed into the in-flight FIFO at the N edge, so outstanding increments visibly in N+1.
  - credit[winner] decrements at the N edge.
  - lockout_q=winner for cycle N+1 only. The TQU updates ready the cycle after a pop, so ready seen in N+1 is stale.
- Full check: outstanding==MAX_OUT blocks all grants. A same-cycle data return is not counted toward freeing a slot (conservative).
- Data return, when tqu_data_valid=1:
  - FIFO non-empty: pop the FIFO head. Next cycle out_valid=1, out_data=tqu_data, out_qid=head. If tqu_data_qid!=head, set err_order; data is still forwarded.
  - FIFO empty: set err_unexp, out_valid stays 0, FIFO unchanged.
- outstanding counter:
  - push only: +1; pop only: -1; push and pop in the same cycle: unchanged.
  - FIFO pointers wrap modulo MAX_OUT.
- Credits:
  - credit_ret_valid increments credit[credit_ret_qid].
  - If that counter is already at CREDITS: saturate, set err_credit.
  - A return and a pop to the same queue in the same cycle: net unchanged.
  - credit_ret_qid>=NUM_Q: ignored, sets err_credit.
- q_enable deassert only stops new grants; pops already issued still complete.
- Sticky errors clear only on reset.

Optional Feature:
- Macro: EGR_TCU_POP_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle with outstanding>0 and tqu_data_valid=0.
  - Counter clears on any tqu_data_valid or when outstanding==0.
  - When the counter reaches TIMEOUT_CYC, err_timeout is set (sticky) and the counter holds.
- Not defined: no counter is built; err_timeout is tied 0; TIMEOUT_CYC is unused.

Test Plan:
- Reset -> all outputs 0; outstanding=0; after reset with q0 ready, tcu_pop=0x1 exactly one cycle later.
- Queues 3, 7 and 35 held ready, credits ample, data returned 2 cycles after each pop -> pops issued in order 3,7,35,3,7,... with no queue popped in two consecutive cycles.
- Queue 5 alone held ready, no credit returns -> exactly 4 pops, then none; one credit_ret to qid 5 -> exactly one more pop.
- TQU withholds data, 20 queues ready -> pops stop at outstanding=8; one data return -> next grant in the following cycle.
- tqu_data_valid with FIFO empty -> err_unexp=1, out_valid=0; tqu_data_qid=9 while FIFO head is 4 -> err_order=1 and out_qid=4.
- Macro defined, one pop issued, no data for 256 cycles -> err_timeout=1 at cycle 256; macro undefined -> err_timeout stays 0.
